// File: rtl/imem_pkg.sv
// Shared widths, NOP encoding and FSM state type for the loadable instruction memory.
package imem_pkg;
   localparam int IMEM_INSTR_WIDTH = 19;
   localparam int IMEM_ADDR_WIDTH  = 12;
   localparam logic [IMEM_INSTR_WIDTH-1:0] IMEM_NOP = '0;

   typedef enum logic {IMEM_CLEAR, IMEM_READY} imem_state_t;
endpackage

// File: rtl/imem_ram_1r1w.sv
// Plain storage array: one registered read port with enable/hold, one write port,
// write-first bypass when both ports hit the same word on the same edge.
module imem_ram_1r1w #(
   parameter int INSTR_WIDTH = 19,
   parameter int DEPTH       = 4096,
   parameter int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                   clock,
   input  logic                   rd_en,
   input  logic [AW-1:0]          rd_addr,
   output logic [INSTR_WIDTH-1:0] rd_data,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [INSTR_WIDTH-1:0] wr_data
);
   logic [INSTR_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      if (rd_en) begin
         if (wr_en && (wr_addr == rd_addr))
            rd_data <= wr_data;
         else
            rd_data <= mem[rd_addr];
      end
   end
endmodule

// File: rtl/instruction_memory_loadable.sv
// Program store for the fetch stage: registered read with stall hold, runtime load port,
// optional post-reset NOP sweep.
module instruction_memory_loadable
   import imem_pkg::*;
#(
   parameter int INSTR_WIDTH    = IMEM_INSTR_WIDTH,
   parameter int ADDR_WIDTH     = IMEM_ADDR_WIDTH,
   parameter int DEPTH          = 1 << ADDR_WIDTH,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   fetch_req,
   input  logic [ADDR_WIDTH-1:0]  fetch_addr,
   input  logic                   fetch_stall,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic                   instruction_valid,
   input  logic                   load_en,
   input  logic [ADDR_WIDTH-1:0]  load_addr,
   input  logic [INSTR_WIDTH-1:0] load_data,
   output logic                   busy
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   imem_state_t            state, state_next;
   logic [ADDR_WIDTH-1:0]  clear_ptr;
   logic                   fetch_ok, fetch_in_range, load_in_range;
   logic                   rd_en, wr_en, zero_q;
   logic [AW-1:0]          wr_addr;
   logic [INSTR_WIDTH-1:0] wr_data, rd_data;

   assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_W);
   assign load_in_range  = ({1'b0, load_addr} < DEPTH_W);
   assign fetch_ok       = fetch_req & ~busy & ~fetch_stall;
   assign rd_en          = fetch_ok & fetch_in_range;

   always_ff @(posedge clock) begin
      if (reset) begin
         if (CLEAR_ON_RESET)
            state <= IMEM_CLEAR;
         else
            state <= IMEM_READY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      case (state)
         IMEM_CLEAR: begin
            busy = 1'b1;
            if (clear_ptr == LAST_ADDR)
               state_next = IMEM_READY;
         end
         IMEM_READY: state_next = IMEM_READY;
         default:    state_next = IMEM_READY;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset)
         clear_ptr <= '0;
      else if (state == IMEM_CLEAR)
         clear_ptr <= clear_ptr + 1'b1;
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (busy) begin
         wr_en   = 1'b1;
         wr_addr = clear_ptr[AW-1:0];
         wr_data = INSTR_WIDTH'(IMEM_NOP);
      end else begin
         wr_en   = load_en & load_in_range;
         wr_addr = load_addr[AW-1:0];
         wr_data = load_data;
      end
   end

   // The array has no reset and ignores out-of-range reads, so zero_q forces the
   // output to 0 after reset and after an out-of-range fetch; it holds with the data.
   always_ff @(posedge clock) begin
      if (reset) begin
         instruction_valid <= 1'b0;
         zero_q            <= 1'b1;
      end else if (!fetch_stall) begin
         instruction_valid <= fetch_ok;
         if (fetch_ok)
            zero_q <= ~fetch_in_range;
      end
   end

   assign instruction = zero_q ? '0 : rd_data;

   imem_ram_1r1w #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .DEPTH       (DEPTH),
      .AW          (AW)
   ) u_ram (
      .clock   (clock),
      .rd_en   (rd_en),
      .rd_addr (fetch_addr[AW-1:0]),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );
endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed bench: clearing instance (DEPTH=16) and a keep-contents instance share stimulus.
module tb_instruction_memory_loadable;
   localparam logic [18:0] W0 = {3'b100, 2'b00, 3'b001, 3'b000, 8'd100};
   localparam logic [18:0] W1 = 19'h2AAAA;
   localparam logic [18:0] W2 = 19'h11111;
   localparam logic [18:0] W4 = 19'h0ABCD;
   localparam logic [18:0] W7 = 19'h5A5A5;

   logic        clock = 1'b0;
   logic        reset_c = 1'b0, reset_k = 1'b0;
   logic        fetch_req = 1'b0, fetch_stall = 1'b0, load_en = 1'b0;
   logic [11:0] fetch_addr = '0, load_addr = '0;
   logic [18:0] load_data = '0;
   logic [18:0] instr_c, instr_k;
   logic        valid_c, valid_k, busy_c, busy_k;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   instruction_memory_loadable #(
      .INSTR_WIDTH(19), .ADDR_WIDTH(12), .DEPTH(16), .CLEAR_ON_RESET(1'b1)
   ) dut_c (
      .clock(clock), .reset(reset_c), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_stall(fetch_stall), .instruction(instr_c), .instruction_valid(valid_c),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy_c)
   );

   instruction_memory_loadable #(
      .INSTR_WIDTH(19), .ADDR_WIDTH(12), .DEPTH(16), .CLEAR_ON_RESET(1'b0)
   ) dut_k (
      .clock(clock), .reset(reset_k), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_stall(fetch_stall), .instruction(instr_k), .instruction_valid(valid_k),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy_k)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      int cnt;
      bit bad_valid;
      reset_c = 1'b1; reset_k = 1'b1;
      step();
      reset_c = 1'b0; reset_k = 1'b0;
      n_cmp++; if (instr_c !== 19'h0) begin n_fail++; $display("FAIL reset_instr got %h want %h", instr_c, 19'h0); end
      n_cmp++; if (valid_c !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_c); end
      n_cmp++; if (busy_c !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", busy_c); end
      n_cmp++; if (busy_k !== 1'b0) begin n_fail++; $display("FAIL keep_busy got %b want 0", busy_k); end
      cnt = 0; bad_valid = 1'b0;
      while (busy_c === 1'b1 && cnt < 40) begin
         if (valid_c !== 1'b0) bad_valid = 1'b1;
         // fetches and loads during the sweep must be dropped
         fetch_req = (cnt < 10); fetch_addr = 12'd5;
         load_en = (cnt < 10); load_addr = 12'd5; load_data = 19'h7FFFF;
         cnt++;
         step();
      end
      fetch_req = 1'b0; load_en = 1'b0;
      n_cmp++; if (cnt != 16) begin n_fail++; $display("FAIL busy_cycles got %0d want 16", cnt); end
      n_cmp++; if (bad_valid !== 1'b0) begin n_fail++; $display("FAIL valid_during_busy got 1 want 0"); end
      fetch_req = 1'b1; fetch_addr = 12'd5;
      step();
      fetch_req = 1'b0;
      n_cmp++; if (instr_c !== 19'h0) begin n_fail++; $display("FAIL cleared_addr5 got %h want %h", instr_c, 19'h0); end
      n_cmp++; if (valid_c !== 1'b1) begin n_fail++; $display("FAIL cleared_valid got %b want 1", valid_c); end
      step();
   endtask

   task automatic test_load_fetch();
      load_en = 1'b1; load_addr = 12'd0; load_data = W0;
      step();
      load_en = 1'b0;
      n_cmp++; if (valid_c !== 1'b0) begin n_fail++; $display("FAIL load_no_valid got %b want 0", valid_c); end
      fetch_req = 1'b1; fetch_addr = 12'd0;
      step();
      fetch_req = 1'b0;
      n_cmp++; if (instr_c !== W0) begin n_fail++; $display("FAIL load_fetch_instr got %h want %h", instr_c, W0); end
      n_cmp++; if (valid_c !== 1'b1) begin n_fail++; $display("FAIL load_fetch_valid got %b want 1", valid_c); end
      step();
      n_cmp++; if (valid_c !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", valid_c); end
      n_cmp++; if (instr_c !== W0) begin n_fail++; $display("FAIL idle_hold got %h want %h", instr_c, W0); end
   endtask

   task automatic test_stall();
      load_en = 1'b1; load_addr = 12'd1; load_data = W1;
      step();
      load_en = 1'b0;
      fetch_req = 1'b1; fetch_addr = 12'd0;
      step();
      fetch_stall = 1'b1; fetch_addr = 12'd1;
      for (int i = 0; i < 3; i++) begin
         load_en = (i == 0); load_addr = 12'd2; load_data = W2;
         step();
         n_cmp++; if (instr_c !== W0) begin n_fail++; $display("FAIL stall_instr[%0d] got %h want %h", i, instr_c, W0); end
         n_cmp++; if (valid_c !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b want 1", i, valid_c); end
      end
      load_en = 1'b0; fetch_stall = 1'b0;
      step();
      n_cmp++; if (instr_c !== W1) begin n_fail++; $display("FAIL unstall_instr got %h want %h", instr_c, W1); end
      fetch_addr = 12'd2;
      step();
      fetch_req = 1'b0;
      n_cmp++; if (instr_c !== W2) begin n_fail++; $display("FAIL stall_load got %h want %h", instr_c, W2); end
      step();
   endtask

   task automatic test_bypass();
      load_en = 1'b1; load_addr = 12'd7; load_data = W7;
      fetch_req = 1'b1; fetch_addr = 12'd7;
      step();
      load_en = 1'b0; fetch_req = 1'b0;
      n_cmp++; if (instr_c !== W7) begin n_fail++; $display("FAIL bypass_instr got %h want %h", instr_c, W7); end
      n_cmp++; if (valid_c !== 1'b1) begin n_fail++; $display("FAIL bypass_valid got %b want 1", valid_c); end
      step();
   endtask

   task automatic test_range();
      load_en = 1'b1; load_addr = 12'd4; load_data = W4;
      step();
      load_addr = 12'd20; load_data = 19'h7FFFF;
      step();
      load_en = 1'b0;
      fetch_req = 1'b1; fetch_addr = 12'd20;
      step();
      n_cmp++; if (instr_c !== 19'h0) begin n_fail++; $display("FAIL oor_read got %h want %h", instr_c, 19'h0); end
      n_cmp++; if (valid_c !== 1'b1) begin n_fail++; $display("FAIL oor_valid got %b want 1", valid_c); end
      fetch_addr = 12'd4;
      step();
      n_cmp++; if (instr_c !== W4) begin n_fail++; $display("FAIL no_wrap_addr4 got %h want %h", instr_c, W4); end
      fetch_addr = 12'd4095;
      step();
      fetch_req = 1'b0;
      n_cmp++; if (instr_c !== 19'h0) begin n_fail++; $display("FAIL oor_top got %h want %h", instr_c, 19'h0); end
      step();
   endtask

   task automatic test_back_to_back();
      logic [11:0] addrs [4];
      logic [18:0] exp [4];
      addrs = '{12'd0, 12'd1, 12'd2, 12'd7};
      exp   = '{W0, W1, W2, W7};
      fetch_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         fetch_addr = addrs[i];
         step();
         n_cmp++; if (instr_c !== exp[i] || valid_c !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d] got %h/%b want %h/1", i, instr_c, valid_c, exp[i]); end
      end
      fetch_req = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_clear();
      int cnt;
      reset_c = 1'b1;
      step();
      reset_c = 1'b0;
      for (int i = 0; i < 9; i++) step();
      n_cmp++; if (busy_c !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b want 1", busy_c); end
      reset_c = 1'b1;
      step();
      reset_c = 1'b0;
      n_cmp++; if (instr_c !== 19'h0 || valid_c !== 1'b0) begin n_fail++; $display("FAIL rereset_out got %h/%b want 0/0", instr_c, valid_c); end
      cnt = 0;
      while (busy_c === 1'b1 && cnt < 40) begin
         cnt++;
         step();
      end
      n_cmp++; if (cnt != 16) begin n_fail++; $display("FAIL restart_busy_cycles got %0d want 16", cnt); end
      fetch_req = 1'b1; fetch_addr = 12'd0;
      step();
      n_cmp++; if (instr_c !== 19'h0) begin n_fail++; $display("FAIL swept_addr0 got %h want %h", instr_c, 19'h0); end
      fetch_addr = 12'd7;
      step();
      fetch_req = 1'b0;
      n_cmp++; if (instr_c !== 19'h0) begin n_fail++; $display("FAIL swept_addr7 got %h want %h", instr_c, 19'h0); end
      step();
   endtask

   task automatic test_keep();
      load_en = 1'b1; load_addr = 12'd3; load_data = 19'h33333;
      step();
      load_addr = 12'd9; load_data = 19'h4C0DE;
      step();
      load_en = 1'b0;
      reset_k = 1'b1;
      step();
      reset_k = 1'b0;
      n_cmp++; if (instr_k !== 19'h0 || valid_k !== 1'b0 || busy_k !== 1'b0) begin n_fail++; $display("FAIL keep_reset got %h/%b/%b want 0/0/0", instr_k, valid_k, busy_k); end
      fetch_req = 1'b1; fetch_addr = 12'd3;
      step();
      n_cmp++; if (instr_k !== 19'h33333 || valid_k !== 1'b1) begin n_fail++; $display("FAIL keep_addr3 got %h/%b want 33333/1", instr_k, valid_k); end
      fetch_addr = 12'd9;
      step();
      n_cmp++; if (instr_k !== 19'h4C0DE) begin n_fail++; $display("FAIL keep_addr9 got %h want %h", instr_k, 19'h4C0DE); end
      fetch_addr = 12'd0;
      step();
      fetch_req = 1'b0;
      n_cmp++; if (instr_k !== W0) begin n_fail++; $display("FAIL keep_addr0 got %h want %h", instr_k, W0); end
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      step();
      test_reset();
      test_load_fetch();
      test_stall();
      test_bypass();
      test_range();
      test_back_to_back();
      test_reset_mid_clear();
      test_keep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
